// File: rtl/phase_acc_gen_if.sv
// rtl/phase_acc_gen_if.sv - control, symbol-source and phase-output bundle for phase_acc_gen
interface phase_acc_gen_if #(
    parameter int CNT_W   = 6,
    parameter int PHASE_W = 10,
    parameter int SYM_W   = 3
);
    logic               en;
    logic               clr;
    logic [CNT_W-1:0]   sps_m1;
    logic [1:0]         mode;
    logic [PHASE_W-1:0] fcw;
    logic [SYM_W-1:0]   sym_data;
    logic               sym_req;
    logic               sym_strobe;
    logic [CNT_W-1:0]   sample_count;
    logic [PHASE_W-1:0] carrier_phase;
    logic [PHASE_W-1:0] mod_phase;
    logic [1:0]         quadrant;
    logic               sign;
    logic [1:0]         active_mode;

    modport master (
        output en, clr, sps_m1, mode, fcw, sym_data,
        input  sym_req, sym_strobe, sample_count, carrier_phase,
               mod_phase, quadrant, sign, active_mode
    );

    modport slave (
        input  en, clr, sps_m1, mode, fcw, sym_data,
        output sym_req, sym_strobe, sample_count, carrier_phase,
               mod_phase, quadrant, sign, active_mode
    );
endinterface

// File: rtl/phase_acc_gen.sv
// rtl/phase_acc_gen.sv - carrier phase accumulator with symbol-timed PSK phase offset
module phase_acc_gen #(
    parameter int CNT_W   = 6,
    parameter int PHASE_W = 10,
    parameter int SYM_W   = 3
) (
    input  logic           clk,
    input  logic           rst,
    phase_acc_gen_if.slave bus
);
    logic [CNT_W-1:0]   sample_count;
    logic [CNT_W-1:0]   sps_lat;
    logic [1:0]         mode_lat;
    logic [PHASE_W-1:0] carrier_phase;
    logic [PHASE_W-1:0] sym_offset;
    logic [PHASE_W-1:0] next_offset;
    logic               sym_strobe;
    logic               boundary;
    logic [PHASE_W-1:0] mod_phase;

    assign boundary = bus.en & ~bus.clr & (sample_count == sps_lat);

    // Offset uses the mode presented at the boundary, not the one in effect for the ending symbol.
    always_comb begin
        next_offset = sym_offset;
        case (bus.mode)
            2'd0:    next_offset = PHASE_W'(bus.sym_data[0]) << (PHASE_W - 1);
            2'd1:    next_offset = PHASE_W'(bus.sym_data[1:0]) << (PHASE_W - 2);
            2'd2:    next_offset = PHASE_W'(bus.sym_data[2:0]) << (PHASE_W - 3);
            default: next_offset = sym_offset + (PHASE_W'(bus.sym_data[1:0]) << (PHASE_W - 2));
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_count  <= '0;
            carrier_phase <= '0;
            sym_offset    <= '0;
            sym_strobe    <= 1'b0;
            sps_lat       <= '1;
            mode_lat      <= 2'd1;
        end else if (bus.clr) begin
            sample_count  <= '0;
            carrier_phase <= '0;
            sym_offset    <= '0;
            sym_strobe    <= 1'b0;
            sps_lat       <= bus.sps_m1;
            mode_lat      <= bus.mode;
        end else if (bus.en) begin
            carrier_phase <= carrier_phase + bus.fcw;
            if (boundary) begin
                sample_count <= '0;
                sps_lat      <= bus.sps_m1;
                mode_lat     <= bus.mode;
                sym_strobe   <= 1'b1;
                sym_offset   <= next_offset;
            end else begin
                sample_count <= sample_count + CNT_W'(1);
                sym_strobe   <= 1'b0;
            end
        end else begin
            sym_strobe <= 1'b0;
        end
    end

    assign mod_phase         = carrier_phase + sym_offset;
    assign bus.sym_req       = boundary;
    assign bus.sym_strobe    = sym_strobe;
    assign bus.sample_count  = sample_count;
    assign bus.carrier_phase = carrier_phase;
    assign bus.mod_phase     = mod_phase;
    assign bus.quadrant      = mod_phase[PHASE_W-1 -: 2];
    assign bus.sign          = mod_phase[PHASE_W-1];
    assign bus.active_mode   = mode_lat;
endmodule

// File: tb/tb_phase_acc_gen.sv
// tb/tb_phase_acc_gen.sv - directed-vector bench for phase_acc_gen
module tb_phase_acc_gen;
    localparam int CNT_W   = 6;
    localparam int PHASE_W = 10;
    localparam int SYM_W   = 3;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    phase_acc_gen_if #(.CNT_W(CNT_W), .PHASE_W(PHASE_W), .SYM_W(SYM_W)) bus ();

    phase_acc_gen #(.CNT_W(CNT_W), .PHASE_W(PHASE_W), .SYM_W(SYM_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr_pulse();
        bus.clr = 1'b1;
        step(1);
        bus.clr = 1'b0;
        #1;
    endtask

    task automatic wait_req(input int bound, output int n);
        n = 0;
        while (!bus.sym_req && n < bound) begin
            step(1);
            n++;
        end
    endtask

    int exp_mod  [4] = '{256, 512, 768, 0};
    int exp_quad [4] = '{1, 2, 3, 0};
    int exp_sign [4] = '{0, 1, 1, 0};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        bus.en = 1'b0; bus.clr = 1'b0; bus.sps_m1 = 6'd63; bus.mode = 2'd1;
        bus.fcw = '0; bus.sym_data = 3'd1;
        #12;
        chk("rst_count", bus.sample_count, 0);
        chk("rst_carrier", bus.carrier_phase, 0);
        chk("rst_mod", bus.mod_phase, 0);
        chk("rst_quad", bus.quadrant, 0);
        chk("rst_sign", bus.sign, 0);
        chk("rst_strobe", bus.sym_strobe, 0);
        chk("rst_req", bus.sym_req, 0);
        chk("rst_mode", bus.active_mode, 1);

        // Default 64-sample symbol; sps_m1 change mid-symbol waits for the boundary.
        rst = 1'b0;
        bus.en = 1'b1;
        step(10);
        bus.sps_m1 = 6'd3;
        step(52);
        chk("t1_count62", bus.sample_count, 62);
        chk("t1_req_early", bus.sym_req, 0);
        step(1);
        chk("t1_req63", bus.sym_req, 1);
        step(1);
        chk("t1_strobe", bus.sym_strobe, 1);
        chk("t1_count0", bus.sample_count, 0);
        chk("t1_mod", bus.mod_phase, 256);
        chk("t1_quad", bus.quadrant, 1);
        chk("t1_sign", bus.sign, 0);
        wait_req(100, n);
        chk("t2_sym_len_a", n, 3);
        step(1);
        chk("t2_strobe_a", bus.sym_strobe, 1);
        step(1);
        chk("t2_strobe_drop", bus.sym_strobe, 0);
        wait_req(100, n);
        chk("t2_sym_len_b", n, 2);

        bus.sps_m1 = 6'd63;
        clr_pulse();
        step(5);
        chk("t2_len63_count", bus.sample_count, 5);
        chk("t2_len63_req", bus.sym_req, 0);
        bus.sps_m1 = 6'd3;
        clr_pulse();
        chk("t2_clr_count", bus.sample_count, 0);
        wait_req(100, n);
        chk("t2_clr_len", n, 3);

        // Carrier wrap and en=0 hold.
        bus.fcw = 10'd100; bus.mode = 2'd0; bus.sym_data = 3'd0; bus.sps_m1 = 6'd63;
        clr_pulse();
        chk("t3_clr_carrier", bus.carrier_phase, 0);
        step(11);
        chk("t3_carrier", bus.carrier_phase, 76);
        chk("t3_count", bus.sample_count, 11);
        chk("t3_mod", bus.mod_phase, 76);
        bus.en = 1'b0;
        #1;
        chk("t3_req_off", bus.sym_req, 0);
        step(5);
        chk("t3_hold_carrier", bus.carrier_phase, 76);
        chk("t3_hold_count", bus.sample_count, 11);
        chk("t3_hold_strobe", bus.sym_strobe, 0);

        // Differential QPSK accumulates a quarter turn per symbol.
        bus.en = 1'b1; bus.fcw = '0; bus.mode = 2'd3; bus.sym_data = 3'd1; bus.sps_m1 = 6'd3;
        clr_pulse();
        chk("t4_mode_lat", bus.active_mode, 3);
        chk("t4_clr_mod", bus.mod_phase, 0);
        for (int k = 0; k < 4; k++) begin
            step(4);
            chk($sformatf("t4_strobe%0d", k), bus.sym_strobe, 1);
            chk($sformatf("t4_mod%0d", k), bus.mod_phase, exp_mod[k]);
            chk($sformatf("t4_quad%0d", k), bus.quadrant, exp_quad[k]);
            chk($sformatf("t4_sign%0d", k), bus.sign, exp_sign[k]);
        end
        step(4);
        chk("t5_diff_again", bus.mod_phase, 256);

        // Leaving differential mode overwrites the offset; unused bits ignored.
        bus.mode = 2'd0; bus.sym_data = 3'b110;
        step(4);
        chk("t5_bpsk_110", bus.mod_phase, 0);
        bus.sym_data = 3'b111;
        step(4);
        chk("t5_bpsk_111", bus.mod_phase, 512);
        bus.mode = 2'd2; bus.sym_data = 3'd5;
        step(4);
        chk("t5_8psk_5", bus.mod_phase, 640);
        chk("t5_8psk_quad", bus.quadrant, 2);
        chk("t5_8psk_sign", bus.sign, 1);

        // Asynchronous reset mid-symbol.
        bus.fcw = 10'd5; bus.sps_m1 = 6'd63;
        clr_pulse();
        step(20);
        chk("t6_pre_count", bus.sample_count, 20);
        chk("t6_pre_carrier", bus.carrier_phase, 100);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_count", bus.sample_count, 0);
        chk("t6_async_carrier", bus.carrier_phase, 0);
        chk("t6_async_mod", bus.mod_phase, 0);
        chk("t6_async_strobe", bus.sym_strobe, 0);
        chk("t6_async_mode", bus.active_mode, 1);
        step(1);
        rst = 1'b0;
        bus.sps_m1 = 6'd0;
        clr_pulse();
        chk("t6_sps0_req0", bus.sym_req, 1);
        chk("t6_sps0_strobe0", bus.sym_strobe, 0);
        for (int k = 1; k <= 3; k++) begin
            step(1);
            chk($sformatf("t6_sps0_req%0d", k), bus.sym_req, 1);
            chk($sformatf("t6_sps0_strobe%0d", k), bus.sym_strobe, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/phase_acc_gen.md
Name: phase_acc_gen

Overview:
Parametrised carrier/symbol phase generator for the digital modulator datapath. A programmable samples-per-symbol counter sets symbol timing, and a free-running carrier phase accumulator advances each sample. A symbol-dependent phase offset is added for BPSK, QPSK, 8PSK or differential QPSK. It feeds the sine/cosine lookup and exposes quadrant/sign for the legacy sign/phase consumers.

Parameters:
CNT_W, 6, width of the sample counter; maximum samples per symbol is 2^CNT_W.
PHASE_W, 10, phase accumulator width. 2^PHASE_W is one full carrier cycle. Must be ≥ 3.
SYM_W, 3, width of sym_data. Must be ≥ 3.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
en  in  1  sample enable; all state advances only when high
clr  in  1  synchronous clear; priority over en
sps_m1  in  CNT_W  samples per symbol minus 1; sampled at symbol boundary
mode  in  2  0=BPSK, 1=QPSK, 2=8PSK, 3=differential QPSK; sampled at symbol boundary
fcw  in  PHASE_W  carrier frequency control word; used every enabled cycle
sym_data  in  SYM_W  next symbol; must be valid while sym_req is high
sym_req  out  1  symbol request / boundary indicator (combinational)
sym_strobe  out  1  registered one-cycle pulse: new symbol in effect
sample_count  out  CNT_W  current sample index within symbol
carrier_phase  out  PHASE_W  carrier accumulator value
mod_phase  out  PHASE_W  carrier_phase + sym_offset, modulo 2^PHASE_W (combinational)
quadrant  out  2  mod_phase[PHASE_W-1:PHASE_W-2]
sign  out  1  mod_phase[PHASE_W-1]

Behaviour:
- Reset (async):
  - sample_count=0, carrier_phase=0, sym_offset=0, sym_strobe=0.
  - sps_lat = all ones (2^CNT_W-1, so 64 samples by default). mode_lat=1 (QPSK).
- Resulting post-reset outputs: mod_phase=0, quadrant=0, sign=0.
- Boundary condition: sym_req = en & ~clr & (sample_count == sps_lat). The source is sampled on the clock edge that ends that cycle.
- Every enabled cycle: carrier_phase <= carrier_phase + fcw, wrapping mod 2^PHASE_W with no saturation.
- Non-boundary enabled cycle: sample_count increments; sym_strobe <= 0.
- Boundary enabled cycle, all in the same edge:
  - sample_count <= 0.
  - sps_lat <= sps_m1; mode_lat <= mode.
  - sym_strobe <= 1.
  - sym_offset updates from the sampled mode and sym_data:
    - mode 0: sym_data[0] << (PHASE_W-1), i.e. 0° or 180°.
    - mode 1: sym_data[1:0] << (PHASE_W-2).
    - mode 2: sym_data[2:0] << (PHASE_W-3).
    - mode 3: sym_offset + (sym_data[1:0] << (PHASE_W-2)), mod 2^PHASE_W (accumulates).
  - Unused sym_data bits are ignored.
- The new symbol offset appears on mod_phase in the cycle sym_strobe is high. Latency from sym_req to new offset is 1 cycle.
- Config changes on sps_m1/mode mid-symbol have no effect until the next boundary. The current symbol length always uses sps_lat.
- sps_lat=0: every enabled cycle is a boundary; sym_req stays high while en=1; sym_strobe stays high on consecutive cycles.
- en=0: all registers hold; sym_req=0; sym_strobe <= 0.
- clr=1 (regardless of en):
  - sample_count, carrier_phase and sym_offset go to 0; sym_strobe <= 0.
  - sps_lat <= sps_m1; mode_lat <= mode.
  - sym_data is not consumed.
- Switching from mode 3 to 0–2 overwrites the offset. Switching into mode 3 accumulates from the current offset.
- rst mid-symbol: immediate return to reset state. The first symbol after release is 2^CNT_W samples unless clr is used to load sps_m1.

Test Plan:
1. Defaults, en=1, fcw=0, mode=1, sym_data=1 held: sym_req high at sample_count=63 (64th enabled cycle). Next cycle: sym_strobe=1, sample_count=0, mod_phase=256, quadrant=1, sign=0.
2. sps_m1=3 applied at cycle 10 after reset: first symbol still 64 samples; subsequent sym_req every 4 cycles; clr with sps_m1=3 gives 4-sample symbols immediately.
3. fcw=100, mode=0, sym_data=0: after 11 enabled cycles carrier_phase=76 (1100 mod 1024). en=0 for 5 cycles holds carrier_phase=76 and sample_count, with sym_req=0.
4. mode=3, sym_data=1 every symbol, fcw=0: mod_phase steps 256, 512, 768, 0. quadrant steps 1, 2, 3, 0; sign steps 0, 1, 1, 0.
5. mode=0 with sym_data=3'b110 then 3'b111: offsets 0 then 512. mode=2 with sym_data=5: offset 640.
6. Assert rst asynchronously mid-symbol at sample_count=20, carrier_phase≠0: all outputs return to reset values with no clock edge. sps_m1=0, en=1: sym_req constant high and sym_strobe high every cycle from the second cycle.
